// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the activation/weight/result memory port arbiter.
package mem_port_arbiter_pkg;

  // Memory geometry of the shared single-port RAM.
  localparam int MEM_AW = 12;
  localparam int MEM_DW = 16;

  // Default arbiter configuration: host loader (0) and systolic sequencer (1).
  localparam int DEF_NREQ      = 2;
  localparam int DEF_RD_LAT    = 1;
  localparam int DEF_MAX_BURST = 64;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  // Increment with wrap at n; used for the round-robin pointer and the search order.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake and memory-side bus of the memory port arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus memory.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = MEM_DW,
  parameter int AW    = MEM_AW
);

  logic [NREQ-1:0]            req;
  logic [NREQ-1:0]            we;
  logic [NREQ-1:0][AW-1:0]    addr;
  logic [NREQ-1:0][WIDTH-1:0] wdata;
  logic [NREQ-1:0]            last;
  logic [NREQ-1:0]            gnt;
  logic [NREQ-1:0]            rvalid;
  logic [WIDTH-1:0]           rdata;

  logic [AW-1:0]              mem_addr;
  logic [WIDTH-1:0]           mem_wdata;
  logic                       mem_wren;
  logic [WIDTH-1:0]           mem_q;

  modport slave (
    input  req, we, addr, wdata, last, mem_q,
    output gnt, rvalid, rdata, mem_addr, mem_wdata, mem_wren
  );

  modport master (
    output req, we, addr, wdata, last, mem_q,
    input  gnt, rvalid, rdata, mem_addr, mem_wdata, mem_wren
  );

endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request searching upward from ptr, with wrap.
module mem_port_arbiter_rr_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  // Walk the requesters in priority order starting at the pointer; keep the first hit.
  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = int'(ptr);
    for (int i = 0; i < NREQ; i++) begin
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
      j = wrap_inc(j, NREQ);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Burst-granting round-robin arbiter for the single-port activation/weight/result memory.
// The memory is clocked on ~clk, so an address muxed out during a cycle returns q
// before the next rising edge; read tags follow the data back to the issuing requester.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ARB_IDLE  | no owner; pick next requester round-robin, grant next cycle
// ARB_OWNED | owner holds the port until last beat or burst timeout
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int WIDTH     = MEM_DW,
  parameter int AW        = MEM_AW,
  parameter int RD_LAT    = DEF_RD_LAT,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic                err_timeout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [NREQ-1:0]  rv_pipe_q [RD_LAT];
  logic [NREQ-1:0]  rv_pipe_d [RD_LAT];

  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic             beat;
  logic             beat_last;
  logic             timed_out;
  logic             release_now;

  mem_port_arbiter_rr_picker #(
    .NREQ (NREQ)
  ) u_rr_picker (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Beat acceptance and the combinational owner mux onto the memory port.
  always_comb begin
    beat = (state_q == ARB_OWNED) && bus.req[owner_q] && gnt_q[owner_q] && !rst;
    beat_last     = beat && bus.last[owner_q];
    bus.mem_wren  = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (beat) begin
      bus.mem_wren  = bus.we[owner_q];
      bus.mem_addr  = bus.addr[owner_q];
      bus.mem_wdata = bus.wdata[owner_q];
    end
  end

  // Ownership FSM: grant, burst down-counter, release and timeout flag.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    timed_out   = (cnt_q == '0);
    release_now = beat_last || timed_out;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d         = ARB_OWNED;
          owner_d         = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          cnt_d           = CW'(MAX_BURST - 1);
        end
      end
      ARB_OWNED: begin
        if (release_now) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = IW'(wrap_inc(int'(owner_q), NREQ));
          // A last beat in the terminal cycle is an orderly release, not a timeout.
          err_d   = !beat_last;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Read tag pipeline; the tag entering the final stage also captures mem_q.
  always_comb begin
    rv_pipe_d[0] = '0;
    if (beat && !bus.we[owner_q]) begin
      rv_pipe_d[0][owner_q] = 1'b1;
    end
    for (int i = 1; i < RD_LAT; i++) begin
      rv_pipe_d[i] = rv_pipe_q[i-1];
    end
    rdata_d = (|rv_pipe_d[RD_LAT-1]) ? bus.mem_q : rdata_q;
  end

  // State and output registers; reset drops the grant and discards in-flight tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        rv_pipe_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < RD_LAT; i++) begin
        rv_pipe_q[i] <= rv_pipe_d[i];
      end
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.rvalid  = rv_pipe_q[RD_LAT-1];
  assign bus.rdata   = rdata_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural RAM clocked on the falling edge.
module tb_mem_port_arbiter;

  localparam int NREQ      = 2;
  localparam int WIDTH     = 16;
  localparam int AW        = 12;
  localparam int RD_LAT    = 1;
  localparam int MAX_BURST = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_timeout;
  int   vectors     = 0;
  int   miscompares = 0;

  mem_port_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) bus ();

  mem_port_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .AW(AW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err_timeout (err_timeout)
  );

  logic [WIDTH-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  // Single-port RAM on ~clk: write and read-address capture on the falling edge.
  always @(negedge clk) begin
    if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_q <= mem[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem(input string tag, input logic w, input logic [11:0] a,
                           input logic [15:0] d);
    check({tag, "_wren"}, 32'(bus.mem_wren), 32'(w));
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'(a));
    if (w) check({tag, "_wdata"}, 32'(bus.mem_wdata), 32'(d));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic w, input logic [11:0] a,
                       input logic [15:0] d, input logic l);
    bus.req[i]   = 1'b1;
    bus.we[i]    = w;
    bus.addr[i]  = a;
    bus.wdata[i] = d;
    bus.last[i]  = l;
  endtask

  task automatic drop(input int i);
    bus.req[i]  = 1'b0;
    bus.last[i] = 1'b0;
  endtask

  initial begin
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; bus.last = '0;
    rst = 1'b1;
    tick(); tick();
    check("rst_gnt",    32'(bus.gnt), 'h0);
    check("rst_rvalid", 32'(bus.rvalid), 'h0);
    check("rst_rdata",  32'(bus.rdata), 'h0);
    check("rst_err",    32'(err_timeout), 'h0);
    check("rst_wren",   32'(bus.mem_wren), 'h0);
    rst = 1'b0;
    tick();

    // Single write burst from requester 0: 0x010..0x013 <= 1..4.
    drive(0, 1'b1, 12'h010, 16'd1, 1'b0);
    #1;
    check("wr_pre_gnt",  32'(bus.gnt), 'h0);
    check("wr_pre_wren", 32'(bus.mem_wren), 'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 12'(16 + k), 16'(k + 1), k == 3);
      #1;
      check("wr_gnt", 32'(bus.gnt), 'h1);
      check_mem("wr_beat", 1'b1, 12'(16 + k), 16'(k + 1));
      tick();
    end
    drop(0);
    #1;
    check("wr_rel_gnt",  32'(bus.gnt), 'h0);
    check("wr_rel_wren", 32'(bus.mem_wren), 'h0);
    check("wr_rel_err",  32'(err_timeout), 'h0);

    // Read-back by requester 1.
    drive(1, 1'b0, 12'h010, 16'h0, 1'b0);
    #1;
    check("rd_pre_wren", 32'(bus.mem_wren), 'h0);
    tick();
    check("rd_gnt0",    32'(bus.gnt), 'h2);
    check("rd_rvalid0", 32'(bus.rvalid), 'h0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 1'b0, 12'(16 + k), 16'h0, k == 3);
      #1;
      check_mem("rd_beat", 1'b0, 12'(16 + k), 16'h0);
      if (k > 0) begin
        check("rd_rvalid", 32'(bus.rvalid), 'h2);
        check("rd_rdata",  32'(bus.rdata), 32'(k));
      end
      tick();
    end
    drop(1);
    #1;
    check("rd_rel_gnt",    32'(bus.gnt), 'h0);
    check("rd_last_rvld",  32'(bus.rvalid), 'h2);
    check("rd_last_rdata", 32'(bus.rdata), 'h4);
    tick();
    check("rd_after_rvld",  32'(bus.rvalid), 'h0);
    check("rd_hold_rdata",  32'(bus.rdata), 'h4);

    // Contention straight out of reset.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    drive(0, 1'b1, 12'h030, 16'h00A0, 1'b1);
    drive(1, 1'b1, 12'h031, 16'h00B1, 1'b1);
    #1;
    check("ct_pre_gnt", 32'(bus.gnt), 'h0);
    tick();
    check("ct_gnt_a", 32'(bus.gnt), 'h1);
    check_mem("ct_beat_a", 1'b1, 12'h030, 16'h00A0);
    tick();
    check("ct_idle_gnt",  32'(bus.gnt), 'h0);
    check("ct_idle_wren", 32'(bus.mem_wren), 'h0);
    tick();
    check("ct_gnt_b", 32'(bus.gnt), 'h2);
    check_mem("ct_beat_b", 1'b1, 12'h031, 16'h00B1);
    tick();
    drop(1);
    check("ct_idle2_gnt", 32'(bus.gnt), 'h0);
    tick();
    check("ct_gnt_c", 32'(bus.gnt), 'h1);
    check_mem("ct_beat_c", 1'b1, 12'h030, 16'h00A0);
    tick();
    drop(0);
    check("ct_rel_gnt", 32'(bus.gnt), 'h0);
    tick();

    // Timeout: requester 0 never sends last, requester 1 waits.
    drive(0, 1'b1, 12'h040, 16'h0055, 1'b0);
    tick();
    drive(1, 1'b0, 12'h010, 16'h0, 1'b1);
    for (int i = 0; i < MAX_BURST; i++) begin
      #1;
      check("to_gnt", 32'(bus.gnt), 'h1);
      check("to_err", 32'(err_timeout), 'h0);
      if (i == MAX_BURST - 1) check_mem("to_final_beat", 1'b1, 12'h040, 16'h0055);
      tick();
    end
    drop(0);
    #1;
    check("to_rel_gnt", 32'(bus.gnt), 'h0);
    check("to_err_hi",  32'(err_timeout), 'h1);
    tick();
    check("to_err_lo",  32'(err_timeout), 'h0);
    check("to_next_gnt", 32'(bus.gnt), 'h2);
    check_mem("to_next_beat", 1'b0, 12'h010, 16'h0);
    tick();
    drop(1);
    check("to_next_rel",   32'(bus.gnt), 'h0);
    check("to_next_rvld",  32'(bus.rvalid), 'h2);
    check("to_next_rdata", 32'(bus.rdata), 'h1);
    tick();

    // last in the terminal cycle: orderly release, no timeout flag.
    drive(0, 1'b1, 12'h041, 16'h0066, 1'b0);
    tick();
    for (int i = 0; i < MAX_BURST; i++) begin
      if (i == MAX_BURST - 1) bus.last[0] = 1'b1;
      #1;
      check("tl_gnt", 32'(bus.gnt), 'h1);
      tick();
    end
    drop(0);
    #1;
    check("tl_rel_gnt", 32'(bus.gnt), 'h0);
    check("tl_err",     32'(err_timeout), 'h0);
    tick();

    // Reset mid-burst with reads in flight from requester 1.
    drive(1, 1'b0, 12'h011, 16'h0, 1'b0);
    tick();
    check("rm_gnt", 32'(bus.gnt), 'h2);
    #1;
    check_mem("rm_beat", 1'b0, 12'h011, 16'h0);
    tick();
    check("rm_rvld",  32'(bus.rvalid), 'h2);
    check("rm_rdata", 32'(bus.rdata), 'h2);
    drive(1, 1'b0, 12'h012, 16'h0, 1'b0);
    rst = 1'b1;
    tick();
    check("rm_rst_gnt",   32'(bus.gnt), 'h0);
    check("rm_rst_rvld",  32'(bus.rvalid), 'h0);
    check("rm_rst_rdata", 32'(bus.rdata), 'h0);
    drive(0, 1'b1, 12'h020, 16'hBEEF, 1'b1);
    tick();
    check("rm_rst2_rvld", 32'(bus.rvalid), 'h0);
    rst = 1'b0;
    tick();
    check("rm_ptr0_gnt", 32'(bus.gnt), 'h1);
    check("rm_no_rvld",  32'(bus.rvalid), 'h0);
    #1;
    check_mem("rm_wr_beef", 1'b1, 12'h020, 16'hBEEF);
    tick();
    drop(0);
    drop(1);
    check("rm_rel_gnt", 32'(bus.gnt), 'h0);
    tick();

    // Single-beat read on the last beat returns after the grant drops.
    drive(0, 1'b0, 12'h020, 16'h0, 1'b1);
    tick();
    check("rl_gnt", 32'(bus.gnt), 'h1);
    #1;
    check_mem("rl_beat", 1'b0, 12'h020, 16'h0);
    tick();
    drop(0);
    check("rl_rel_gnt", 32'(bus.gnt), 'h0);
    check("rl_rvld",    32'(bus.rvalid), 'h1);
    check("rl_rdata",   32'(bus.rdata), 'hBEEF);
    tick();
    check("rl_rvld_lo", 32'(bus.rvalid), 'h0);
    check("rl_hold",    32'(bus.rdata), 'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
